// File: rtl/regfile_mp.sv
// Multi-port integer register file with two prioritised write ports, optional
// write-to-read bypass and a per-register pending scoreboard for issue stalls.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                we_a_i,
  input  logic [AW-1:0]       waddr_a_i,
  input  logic [XLEN-1:0]     wdata_a_i,
  input  logic                we_b_i,
  input  logic [AW-1:0]       waddr_b_i,
  input  logic [XLEN-1:0]     wdata_b_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  input  logic                resv_i,
  input  logic [AW-1:0]       resv_addr_i,
  output logic [NRD-1:0]      busy_o,
  output logic                wr_conflict_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic             wr_conflict_q, wr_conflict_d;
  logic             wr_a_ok, wr_b_ok, resv_ok;

  // Writes and reserves aimed at a hardwired-zero register are dropped here,
  // so nothing downstream (conflict, bypass, scoreboard) ever sees them.
  assign wr_a_ok = we_a_i && !((ZERO_REG != 0) && (waddr_a_i == '0));
  assign wr_b_ok = we_b_i && !((ZERO_REG != 0) && (waddr_b_i == '0));
  assign resv_ok = resv_i && !((ZERO_REG != 0) && (resv_addr_i == '0));

  always_comb begin
    regs_d        = regs_q;
    pend_d        = pend_q;
    wr_conflict_d = wr_a_ok && wr_b_ok && (waddr_a_i == waddr_b_i);
    if (wr_a_ok) begin
      regs_d[waddr_a_i] = wdata_a_i;
      pend_d[waddr_a_i] = 1'b0;
    end
    // Port B is the younger instruction, so its data lands last.
    if (wr_b_ok) begin
      regs_d[waddr_b_i] = wdata_b_i;
      pend_d[waddr_b_i] = 1'b0;
    end
    // A new producer reserving the register outranks the old one retiring.
    if (resv_ok) begin
      pend_d[resv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pend_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      pend_q        <= pend_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict_o = wr_conflict_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zero_rd, hit_a, hit_b;

    assign ra      = raddr_i[k*AW +: AW];
    assign zero_rd = (ZERO_REG != 0) && (ra == '0);
    assign hit_a   = (BYPASS != 0) && wr_a_ok && (waddr_a_i == ra);
    assign hit_b   = (BYPASS != 0) && wr_b_ok && (waddr_b_i == ra);

    assign rdata_o[k*XLEN +: XLEN] = zero_rd ? {XLEN{1'b0}} :
                                     hit_b   ? wdata_b_i :
                                     hit_a   ? wdata_a_i : regs_q[ra];
    assign busy_o[k] = pend_q[ra] && !(hit_a || hit_b);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default, no-bypass and wide 4-read-port instances.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- instance 0: defaults ----------------
  logic        rst0 = 1'b0, we_a0 = 1'b0, we_b0 = 1'b0, resv0 = 1'b0;
  logic [4:0]  wa_a0 = '0, wa_b0 = '0, rva0 = '0;
  logic [31:0] wd_a0 = '0, wd_b0 = '0;
  logic [4:0]  ra00 = '0, ra01 = '0;
  logic [63:0] rdata0;
  logic [1:0]  busy0;
  logic        conf0;

  regfile_mp u0 (
    .clk_i(clk), .reset_i(rst0),
    .we_a_i(we_a0), .waddr_a_i(wa_a0), .wdata_a_i(wd_a0),
    .we_b_i(we_b0), .waddr_b_i(wa_b0), .wdata_b_i(wd_b0),
    .raddr_i({ra01, ra00}), .rdata_o(rdata0),
    .resv_i(resv0), .resv_addr_i(rva0),
    .busy_o(busy0), .wr_conflict_o(conf0)
  );

  // ---------------- instance 1: no bypass ----------------
  logic        rst1 = 1'b0, we_a1 = 1'b0, we_b1 = 1'b0, resv1 = 1'b0;
  logic [4:0]  wa_a1 = '0, wa_b1 = '0, rva1 = '0;
  logic [31:0] wd_a1 = '0, wd_b1 = '0;
  logic [9:0]  raddr1 = '0;
  logic [63:0] rdata1;
  logic [1:0]  busy1;
  logic        conf1;

  regfile_mp #(.BYPASS(0)) u1 (
    .clk_i(clk), .reset_i(rst1),
    .we_a_i(we_a1), .waddr_a_i(wa_a1), .wdata_a_i(wd_a1),
    .we_b_i(we_b1), .waddr_b_i(wa_b1), .wdata_b_i(wd_b1),
    .raddr_i(raddr1), .rdata_o(rdata1),
    .resv_i(resv1), .resv_addr_i(rva1),
    .busy_o(busy1), .wr_conflict_o(conf1)
  );

  // ---------------- instance 2: 16 x 64, four read ports ----------------
  logic         rst2 = 1'b0, we_a2 = 1'b0, we_b2 = 1'b0, resv2 = 1'b0;
  logic [3:0]   wa_a2 = '0, wa_b2 = '0, rva2 = '0;
  logic [63:0]  wd_a2 = '0, wd_b2 = '0;
  logic [15:0]  raddr2 = '0;
  logic [255:0] rdata2;
  logic [3:0]   busy2;
  logic         conf2;

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) u2 (
    .clk_i(clk), .reset_i(rst2),
    .we_a_i(we_a2), .waddr_a_i(wa_a2), .wdata_a_i(wd_a2),
    .we_b_i(we_b2), .waddr_b_i(wa_b2), .wdata_b_i(wd_b2),
    .raddr_i(raddr2), .rdata_o(rdata2),
    .resv_i(resv2), .resv_addr_i(rva2),
    .busy_o(busy2), .wr_conflict_o(conf2)
  );

  // ---------------- reference model for instance 0 ----------------
  logic [31:0] mregs [32];
  bit          mpend [32];
  bit          mconf;

  function automatic bit m_writes(input logic [4:0] a);
    return a != 0 && ((we_a0 && wa_a0 == a) || (we_b0 && wa_b0 == a));
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (we_b0 && wa_b0 == a) return wd_b0;
    if (we_a0 && wa_a0 == a) return wd_a0;
    return mregs[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    return a != 0 && mpend[a] && !m_writes(a);
  endfunction

  task automatic u0_edge();
    @(posedge clk);
    if (!rst0) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = '0;
        mpend[i] = 1'b0;
      end
      mconf = 1'b0;
    end else begin
      mconf = we_a0 && we_b0 && wa_a0 == wa_b0 && wa_a0 != 0;
      if (we_a0 && wa_a0 != 0) begin mregs[wa_a0] = wd_a0; mpend[wa_a0] = 1'b0; end
      if (we_b0 && wa_b0 != 0) begin mregs[wa_b0] = wd_b0; mpend[wa_b0] = 1'b0; end
      if (resv0 && rva0 != 0) mpend[rva0] = 1'b1;
    end
    #1;
  endtask

  task automatic u0_check_model();
    chk("m_rd0",  rdata0[31:0],  m_rd(ra00));
    chk("m_rd1",  rdata0[63:32], m_rd(ra01));
    chk("m_busy", busy0, {m_busy(ra01), m_busy(ra00)});
    chk("m_conf", conf0, mconf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] v64(input int i);
    return 64'h0123_4567_89AB_CDEF * 64'(i + 1);
  endfunction

  // ---------------- directed vectors for instance 0 ----------------
  typedef struct {
    bit rst; bit we_a; logic [4:0] wa_a; logic [31:0] wd_a;
    bit we_b; logic [4:0] wa_b; logic [31:0] wd_b;
    logic [4:0] ra0; logic [4:0] ra1; bit resv; logic [4:0] rva;
    logic [31:0] e0; logic [31:0] e1; logic [1:0] eb; bit ec;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{0, 1, 5, 32'hFFFF0000, 0, 0, 0,    5, 0, 0, 0, 32'hFFFF0000, 0, 2'b00, 0};
    tbl[1]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0,    5, 5, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0};
    tbl[2]  = '{1, 1, 0, 32'h1234,     0, 0, 0,    5, 0, 0, 0, 32'hDEADBEEF, 0, 2'b00, 0};
    tbl[3]  = '{1, 0, 0, 0,            0, 0, 0,    0, 5, 0, 0, 0, 32'hDEADBEEF, 2'b00, 0};
    tbl[4]  = '{1, 1, 7, 32'h11,       1, 7, 32'h22, 5, 7, 0, 0, 32'hDEADBEEF, 32'h22, 2'b00, 0};
    tbl[5]  = '{1, 0, 0, 0,            0, 0, 0,    7, 7, 0, 0, 32'h22, 32'h22, 2'b00, 1};
    tbl[6]  = '{1, 1, 0, 32'hAA,       1, 0, 32'hBB, 7, 0, 0, 0, 32'h22, 0, 2'b00, 0};
    tbl[7]  = '{1, 0, 0, 0,            0, 0, 0,    9, 9, 1, 9, 0, 0, 2'b00, 0};
    tbl[8]  = '{1, 0, 0, 0,            0, 0, 0,    9, 7, 0, 0, 0, 32'h22, 2'b01, 0};
    tbl[9]  = '{1, 0, 0, 0,            1, 9, 32'h55, 9, 9, 0, 0, 32'h55, 32'h55, 2'b00, 0};
    tbl[10] = '{1, 1, 9, 32'h66,       0, 0, 0,    9, 5, 1, 9, 32'h66, 32'hDEADBEEF, 2'b00, 0};
    tbl[11] = '{1, 0, 0, 0,            0, 0, 0,    9, 9, 0, 0, 32'h66, 32'h66, 2'b11, 0};
    tbl[12] = '{1, 1, 3, 32'h1,        1, 3, 32'h2, 3, 9, 0, 0, 32'h2, 32'h66, 2'b10, 0};
    tbl[13] = '{1, 1, 4, 32'h3,        1, 4, 32'h4, 3, 4, 0, 0, 32'h2, 32'h4, 2'b00, 1};
    tbl[14] = '{1, 0, 0, 0,            0, 0, 0,    4, 3, 0, 0, 32'h4, 32'h2, 2'b00, 1};
    tbl[15] = '{1, 0, 0, 0,            0, 0, 0,    9, 0, 1, 0, 32'h66, 0, 2'b01, 0};
    tbl[16] = '{1, 0, 0, 0,            0, 0, 0,    0, 9, 0, 0, 0, 32'h66, 2'b10, 0};
  end

  task automatic u0_idle();
    rst0 = 1'b1; we_a0 = 1'b0; we_b0 = 1'b0; resv0 = 1'b0;
  endtask

  initial begin
    #1;
    u0_edge();
    u0_edge();
    rst1 = 1'b1;
    rst2 = 1'b1;

    // directed table on the default instance
    for (int i = 0; i < 17; i++) begin
      rst0 = tbl[i].rst;
      we_a0 = tbl[i].we_a; wa_a0 = tbl[i].wa_a; wd_a0 = tbl[i].wd_a;
      we_b0 = tbl[i].we_b; wa_b0 = tbl[i].wa_b; wd_b0 = tbl[i].wd_b;
      ra00 = tbl[i].ra0; ra01 = tbl[i].ra1;
      resv0 = tbl[i].resv; rva0 = tbl[i].rva;
      #2;
      chk($sformatf("tbl%0d_rd0", i),  rdata0[31:0],  tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i),  rdata0[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].eb);
      chk($sformatf("tbl%0d_conf", i), conf0, tbl[i].ec);
      u0_edge();
    end

    // fill, then reset mid-operation with a write in the reset cycle
    u0_idle();
    for (int i = 1; i < 32; i++) begin
      we_a0 = 1'b1; wa_a0 = 5'(i); wd_a0 = 32'hA000_0000 | i;
      u0_edge();
    end
    we_a0 = 1'b1; wa_a0 = 5'd10; wd_a0 = 32'h1;
    we_b0 = 1'b1; wa_b0 = 5'd10; wd_b0 = 32'h2;
    resv0 = 1'b1; rva0 = 5'd4;
    u0_edge();
    rst0 = 1'b0; we_b0 = 1'b0;
    we_a0 = 1'b1; wa_a0 = 5'd2; wd_a0 = 32'h0BAD;
    resv0 = 1'b1; rva0 = 5'd6;
    ra00 = 5'd4; ra01 = 5'd2;
    #2;
    chk("pre_rst_conf", conf0, 1'b1);
    chk("pre_rst_busy4", busy0[0], 1'b1);
    chk("pre_rst_rd4", rdata0[31:0], 32'hA000_0004);
    chk("rst_bypass_r2", rdata0[63:32], 32'h0BAD);
    u0_edge();
    u0_idle();
    for (int a = 0; a < 32; a++) begin
      ra00 = 5'(a); ra01 = 5'(31 - a);
      #2;
      chk($sformatf("post_rst_rd0_a%0d", a), rdata0[31:0], 32'd0);
      chk($sformatf("post_rst_rd1_a%0d", a), rdata0[63:32], 32'd0);
      chk($sformatf("post_rst_busy_a%0d", a), busy0, 2'b00);
      chk($sformatf("post_rst_conf_a%0d", a), conf0, 1'b0);
      u0_edge();
    end

    // randomized traffic against the model; small address pool forces collisions
    for (int n = 0; n < 400; n++) begin
      rst0  = ($urandom_range(0, 31) != 0);
      we_a0 = 1'($urandom_range(0, 1));
      we_b0 = 1'($urandom_range(0, 1));
      resv0 = 1'($urandom_range(0, 1));
      wa_a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wa_b0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rva0  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra00  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra01  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wd_a0 = $urandom;
      wd_b0 = $urandom;
      #2;
      u0_check_model();
      u0_edge();
    end
    u0_idle();

    // no-bypass instance: visibility and busy-clear one cycle after the write
    raddr1 = {5'd3, 5'd3};
    we_a1 = 1'b1; wa_a1 = 5'd3; wd_a1 = 32'hA5;
    #2;
    chk("nb_old_rd", rdata1[31:0], 32'd0);
    tick();
    we_a1 = 1'b0;
    #2;
    chk("nb_new_rd", rdata1[31:0], 32'hA5);
    resv1 = 1'b1; rva1 = 5'd3;
    tick();
    resv1 = 1'b0;
    #2;
    chk("nb_busy_set", busy1, 2'b11);
    we_b1 = 1'b1; wa_b1 = 5'd3; wd_b1 = 32'h5A;
    #2;
    chk("nb_busy_during_wr", busy1[0], 1'b1);
    chk("nb_rd_during_wr", rdata1[63:32], 32'hA5);
    tick();
    we_b1 = 1'b0;
    #2;
    chk("nb_busy_clear", busy1, 2'b00);
    chk("nb_rd_after_wr", rdata1[31:0], 32'h5A);
    we_a1 = 1'b1; wa_a1 = 5'd6; wd_a1 = 32'h1;
    we_b1 = 1'b1; wa_b1 = 5'd6; wd_b1 = 32'h2;
    tick();
    we_a1 = 1'b0; we_b1 = 1'b0;
    raddr1 = {5'd6, 5'd6};
    #2;
    chk("nb_conf", conf1, 1'b1);
    chk("nb_conf_data", rdata1[31:0], 32'h2);
    tick();
    #2;
    chk("nb_conf_drop", conf1, 1'b0);

    // wide instance: fill all 15 writable registers, then read four at once
    for (int i = 1; i < 16; i += 2) begin
      we_a2 = 1'b1; wa_a2 = 4'(i); wd_a2 = v64(i);
      we_b2 = (i + 1 < 16); wa_b2 = 4'(i + 1); wd_b2 = v64(i + 1);
      tick();
    end
    we_a2 = 1'b0; we_b2 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      int ad [4];
      case (c)
        0:       ad = '{1, 2, 3, 4};
        1:       ad = '{15, 8, 0, 7};
        2:       ad = '{12, 12, 5, 10};
        default: for (int k = 0; k < 4; k++) ad[k] = $urandom_range(0, 15);
      endcase
      for (int k = 0; k < 4; k++) raddr2[k*4 +: 4] = 4'(ad[k]);
      #2;
      for (int k = 0; k < 4; k++)
        chk($sformatf("wide_c%0d_p%0d", c, k), rdata2[k*64 +: 64],
            (ad[k] == 0) ? 64'd0 : v64(ad[k]));
      chk($sformatf("wide_c%0d_busy", c), busy2, 4'b0000);
      tick();
    end
    chk("wide_conf", conf2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
